// File: rtl/core_ctrl.sv
// core_ctrl: instruction sequencer that drives the 34-bit inst bus of core for
// one full convolution pass. For each kernel position it performs these steps
// in order: weight SRAM->L0, PE weight load, gap, activation SRAM->L0, execute,
// gap, wait for OFIFO, and OFIFO drain into psum SRAM.
// Ports:
//   clk, reset      clock and synchronous active-high reset
//   start           begin a pass (sampled in IDLE only)
//   mode            0 = 4b/4b (col weight rows), 1 = 2b/4b (2*col rows)
//   ofifo_valid     OFIFO in core holds a full result set
//   inst[33:0]      registered instruction to core
//   busy            high from the first W_L0 cycle through the DONE cycle
//   done            one-cycle pulse at the end of a pass
//   kij[3:0]        current kernel position
module core_ctrl #(
  parameter int unsigned col     = 8,
  parameter int unsigned len_nij = 64,
  parameter int unsigned len_kij = 9,
  parameter int unsigned gap     = 10,
  parameter logic [10:0] w_base  = 11'b10000000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode,
  input  logic        ofifo_valid,
  output logic [33:0] inst,
  output logic        busy,
  output logic        done,
  output logic [3:0]  kij
);

  localparam int unsigned CNT_W = $clog2(len_nij + 3 * col + gap + 2);

  localparam logic [CNT_W-1:0] NW1_C     = CNT_W'(col);
  localparam logic [CNT_W-1:0] NW2_C     = CNT_W'(2 * col);
  localparam logic [CNT_W-1:0] COL_C     = CNT_W'(col);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(gap - 1);
  localparam logic [CNT_W-1:0] NIJ_C     = CNT_W'(len_nij);
  localparam logic [CNT_W-1:0] NIJ_LAST  = CNT_W'(len_nij - 1);
  localparam logic [3:0]       KIJ_LAST  = 4'(len_kij - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_W_L0, S_W_LOAD, S_GAP1, S_X_L0,
    S_EXEC, S_GAP2, S_O_WAIT, S_O_RD, S_DONE
  } state_e;

  typedef struct packed {
    logic        acc;
    logic        cen_pmem;
    logic        wen_pmem;
    logic [10:0] a_pmem;
    logic        cen_xmem;
    logic        wen_xmem;
    logic [10:0] a_xmem;
    logic        ofifo_rd;
    logic        ififo_wr;
    logic        ififo_rd;
    logic        l0_rd;
    logic        l0_wr;
    logic        execute;
    logic        load;
  } inst_t;

  localparam inst_t INST_NOP = inst_t'(34'h1_800C_0000);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       kij_q, kij_d;
  logic             mode_q, mode_d;
  inst_t            inst_q, inst_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] nw_q, nw_d;

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      mode_q  <= 1'b0;
      inst_q  <= INST_NOP;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      mode_q  <= mode_d;
      inst_q  <= inst_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, then instruction decode from the next state so that the
  // registered inst lines up with the cycle the FSM spends in that state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    kij_d   = kij_q;
    mode_d  = mode_q;
    inst_d  = INST_NOP;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    nw_q    = mode_q ? NW2_C : NW1_C;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) begin
          mode_d  = mode;
          kij_d   = '0;
          state_d = S_W_L0;
        end
      end
      S_W_L0: begin
        if (cnt_q == nw_q) begin
          state_d = S_W_LOAD;
          cnt_d   = '0;
        end
      end
      S_W_LOAD: begin
        if (cnt_q == nw_q + COL_C - CNT_W'(1)) begin
          state_d = S_GAP1;
          cnt_d   = '0;
        end
      end
      S_GAP1: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_X_L0;
          cnt_d   = '0;
        end
      end
      S_X_L0: begin
        if (cnt_q == NIJ_C) begin
          state_d = S_EXEC;
          cnt_d   = '0;
        end
      end
      S_EXEC: begin
        if (cnt_q == NIJ_LAST) begin
          state_d = S_GAP2;
          cnt_d   = '0;
        end
      end
      S_GAP2: begin
        if (cnt_q == GAP_LAST) begin
          state_d = S_O_WAIT;
          cnt_d   = '0;
        end
      end
      S_O_WAIT: begin
        cnt_d = '0;
        if (ofifo_valid) state_d = S_O_RD;
      end
      S_O_RD: begin
        if (cnt_q == NIJ_C) begin
          cnt_d = '0;
          if (kij_q == KIJ_LAST) begin
            state_d = S_DONE;
          end else begin
            kij_d   = kij_q + 4'd1;
            state_d = S_W_L0;
          end
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase

    nw_d   = mode_d ? NW2_C : NW1_C;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);

    // l0_wr trails the SRAM read by one cycle to cover read latency
    case (state_d)
      S_W_L0: begin
        if (cnt_d < nw_d) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = w_base + 11'(cnt_d);
        end
        if (cnt_d != '0) inst_d.l0_wr = 1'b1;
      end
      S_W_LOAD: begin
        inst_d.l0_rd = 1'b1;
        inst_d.load  = 1'b1;
      end
      S_X_L0: begin
        if (cnt_d < NIJ_C) begin
          inst_d.cen_xmem = 1'b0;
          inst_d.a_xmem   = 11'(cnt_d);
        end
        if (cnt_d != '0) inst_d.l0_wr = 1'b1;
      end
      S_EXEC: begin
        inst_d.l0_rd   = 1'b1;
        inst_d.execute = 1'b1;
      end
      S_O_RD: begin
        if (cnt_d < NIJ_C) inst_d.ofifo_rd = 1'b1;
        if (cnt_d != '0) begin
          inst_d.cen_pmem = 1'b0;
          inst_d.wen_pmem = 1'b0;
          inst_d.a_pmem   = 11'(32'(kij_d) * len_nij + 32'(cnt_d) - 32'd1);
        end
      end
      default: inst_d = INST_NOP;
    endcase
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;
  assign kij  = kij_q;

endmodule
